mux4_rr_sampler: RTL and testbench

MUX4_RR_SAMPLER -- requirements
Module: mux4_rr_sampler

---
 rtl/mux4_rr_sampler.sv | 126 ++++++++++++
 tb/tb_mux4_rr_sampler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_sampler.sv
// mux4_rr_sampler: round-robin arbiter that drives the select of an external
// 4:1 mux, waits one cycle for the mux to settle, captures its output and
// offers the captured sample on a valid/ready interface. The requester whose
// sample was accepted receives a one-cycle ack pulse, and an 8-bit counter
// tracks accepted samples.
module mux4_rr_sampler #(
  parameter logic [1:0] PTR_INIT = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       y_in,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_data,
  output logic [1:0] out_ch,
  output logic [3:0] ack,
  output logic [7:0] count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_sel;
  logic [3:0] r_gnt;
  logic       r_out_valid;
  logic       r_out_data;
  logic [1:0] r_out_ch;
  logic [3:0] r_ack;
  logic [7:0] r_count;

  logic [1:0] w_win;
  logic       w_req_any;
  logic       w_accept;

  // Circular priority search: the first set request bit at or after the
  // pointer wins. Scanning offsets from high to low lets the smallest offset
  // overwrite the result last.
  function automatic logic [1:0] f_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    f_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) f_pick = idx;
    end
  endfunction

  // One-hot decode of a channel index.
  function automatic logic [3:0] f_onehot(input logic [1:0] idx);
    f_onehot = 4'b0001 << idx;
  endfunction

  // Arbitration result and handshake decode.
  always_comb begin
    w_win     = f_pick(req, r_ptr);
    w_req_any = |req;
    w_accept  = (r_state == S_HOLD) && r_out_valid && out_ready;
  end

  // Control FSM with all outputs registered; reset wins over every event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= PTR_INIT;
      r_sel       <= PTR_INIT;
      r_gnt       <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 1'b0;
      r_out_ch    <= 2'd0;
      r_ack       <= 4'd0;
      r_count     <= 8'd0;
    end else begin
      // ack is a single-cycle pulse; only the accept branch raises it.
      r_ack <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_sel   <= w_win;
            r_gnt   <= f_onehot(w_win);
            r_state <= S_SETTLE;
          end else begin
            r_gnt   <= 4'd0;
          end
        end
        S_SETTLE: begin
          // The mux has had one full cycle to settle on r_sel.
          r_out_data  <= y_in;
          r_out_ch    <= r_sel;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_gnt       <= 4'd0;
            r_ack       <= f_onehot(r_out_ch);
            r_ptr       <= r_out_ch + 2'd1;
            r_count     <= r_count + 8'd1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= 4'd0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign ack       = r_ack;
  assign count     = r_count;

endmodule

// File: tb/tb_mux4_rr_sampler.sv
// Directed bench for mux4_rr_sampler with hand-computed expectations.
module tb_mux4_rr_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       y_in;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       out_valid;
  logic       out_ready;
  logic       out_data;
  logic [1:0] out_ch;
  logic [3:0] ack;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cnt;

  mux4_rr_sampler #(.PTR_INIT(2'd0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .y_in(y_in), .sel(sel), .gnt(gnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .ack(ack), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction with out_ready already high: grant, settle, accept.
  task automatic txn(input logic [3:0] r, input logic yv, input logic [1:0] ch);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    req = r; y_in = yv; out_ready = 1'b1;
    step();
    chk("grant_sel", 32'(sel), 32'(ch));
    chk("grant_gnt", 32'(gnt), 32'(oh));
    chk("grant_valid", 32'(out_valid), 32'd0);
    chk("grant_ack", 32'(ack), 32'd0);
    step();
    chk("settle_valid", 32'(out_valid), 32'd1);
    chk("settle_data", 32'(out_data), 32'(yv));
    chk("settle_ch", 32'(out_ch), 32'(ch));
    chk("settle_ack", 32'(ack), 32'd0);
    step();
    exp_cnt = exp_cnt + 8'd1;
    chk("accept_valid", 32'(out_valid), 32'd0);
    chk("accept_gnt", 32'(gnt), 32'd0);
    chk("accept_ack", 32'(ack), 32'(oh));
    chk("accept_count", 32'(count), 32'(exp_cnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_cnt = 8'd0;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'd0; y_in = 1'b0; out_ready = 1'b0; exp_cnt = 8'd0;
    step();
    step();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_gnt", 32'(gnt), 32'd0);

    // Single request on channel 2, then ptr=3: 0011 -> 0, then 1; 1000 skips to 3.
    txn(4'b0100, 1'b1, 2'd2);
    txn(4'b0011, 1'b0, 2'd0);
    txn(4'b0011, 1'b1, 2'd1);
    txn(4'b1000, 1'b1, 2'd3);
    txn(4'b1000, 1'b0, 2'd3);
    // Idle with no request keeps sel, drops gnt, ends the ack pulse.
    req = 4'd0;
    step();
    chk("idle_hold_sel", 32'(sel), 32'd3);
    chk("idle_gnt0", 32'(gnt), 32'd0);
    chk("idle_ack0", 32'(ack), 32'd0);

    // Round-robin fairness from a fresh pointer.
    do_reset();
    txn(4'b1111, 1'b1, 2'd0);
    txn(4'b1111, 1'b0, 2'd1);
    txn(4'b1111, 1'b1, 2'd2);
    txn(4'b1111, 1'b0, 2'd3);
    txn(4'b1111, 1'b1, 2'd0);
    chk("rr_count5", 32'(count), 32'd5);

    // Backpressure: ptr=1, request channel 1 with out_ready low.
    req = 4'b0010; y_in = 1'b1; out_ready = 1'b0;
    step();
    chk("bp_sel", 32'(sel), 32'd1);
    step();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data", 32'(out_data), 32'd1);
    y_in = 1'b0; req = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'd1);
      chk("bp_hold_ch", 32'(out_ch), 32'd1);
      chk("bp_hold_sel", 32'(sel), 32'd1);
      chk("bp_hold_gnt", 32'(gnt), 32'b0010);
      chk("bp_hold_ack", 32'(ack), 32'd0);
    end
    req = 4'd0; out_ready = 1'b1;
    step();
    chk("bp_ack", 32'(ack), 32'b0010);
    chk("bp_count", 32'(count), 32'd6);
    step();
    chk("bp_ack_once", 32'(ack), 32'd0);

    // Reset in HOLD, coinciding with out_ready, abandons the sample.
    do_reset();
    req = 4'b0100; y_in = 1'b1; out_ready = 1'b0;
    step();
    step();
    chk("hold_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0; out_ready = 1'b1;
    step();
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_ack", 32'(ack), 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_sel", 32'(sel), 32'd0);
    chk("mrst_gnt", 32'(gnt), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    chk("mrst_ch", 32'(out_ch), 32'd0);
    rst_n = 1'b1; req = 4'd0;
    step();
    chk("mrst_ack_after", 32'(ack), 32'd0);

    // Request withdrawn during SETTLE still completes.
    req = 4'b1000; y_in = 1'b1; out_ready = 1'b1;
    step();
    chk("wd_sel", 32'(sel), 32'd3);
    req = 4'd0;
    step();
    chk("wd_valid", 32'(out_valid), 32'd1);
    chk("wd_ch", 32'(out_ch), 32'd3);
    step();
    chk("wd_ack", 32'(ack), 32'b1000);
    chk("wd_count", 32'(count), 32'd1);

    // Counter wrap: 256 accepts from zero.
    do_reset();
    for (int n = 0; n < 256; n++) begin
      txn(4'b0001, n[0], 2'd0);
    end
    chk("wrap_count", 32'(count), 32'd0);
    req = 4'd0;
    step();
    chk("wrap_ack_end", 32'(ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
